// File: rtl/exec_stage_pipe.sv
// Elastic decode-to-execute register: control bundle, two operands, destination address.
// Latency: 1 cycle from input accept to out_valid; sustains 1 entry/cycle.
// Backpressure: 2-entry skid (main + skid); in_ready is a flop, so out_ready never reaches it combinationally.
module exec_stage_pipe #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 4,
  parameter int CTRL_W = 5,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] ctrl_in,
  input  logic [DATA_W-1:0] src1_in,
  input  logic [DATA_W-1:0] src2_in,
  input  logic [ADDR_W-1:0] dest_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] ctrl_out,
  output logic [DATA_W-1:0] src1_out,
  output logic [DATA_W-1:0] src2_out,
  output logic [ADDR_W-1:0] dest_out,
  output logic [CNT_W-1:0]  bubble_cnt
);

  typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;

  typedef struct packed {
    logic [CTRL_W-1:0] ctrl;
    logic [DATA_W-1:0] src1;
    logic [DATA_W-1:0] src2;
    logic [ADDR_W-1:0] dest;
  } entry_t;

  state_t            state, stateNext;
  entry_t            mainQ, mainNext;
  entry_t            skidQ, skidNext;
  entry_t            inEntry;
  logic              inReadyQ;
  logic              inAccept, outAccept;
  logic [CNT_W-1:0]  bubbleQ;

  assign inEntry   = '{ctrl: ctrl_in, src1: src1_in, src2: src2_in, dest: dest_in};
  assign in_ready  = inReadyQ;
  assign out_valid = (state != EMPTY);
  assign inAccept  = in_valid & inReadyQ;
  assign outAccept = out_valid & out_ready;

  // Bubbles read as zero even if main were stale, so no write-enable leaks downstream.
  assign ctrl_out   = out_valid ? mainQ.ctrl : '0;
  assign src1_out   = out_valid ? mainQ.src1 : '0;
  assign src2_out   = out_valid ? mainQ.src2 : '0;
  assign dest_out   = out_valid ? mainQ.dest : '0;
  assign bubble_cnt = bubbleQ;

  // Next-state and payload movement; flush overrides everything and drops any same-cycle accept.
  always_comb begin
    stateNext = state;
    mainNext  = mainQ;
    skidNext  = skidQ;
    case (state)
      EMPTY: begin
        if (inAccept) begin
          stateNext = ONE;
          mainNext  = inEntry;
        end
      end
      ONE: begin
        if (inAccept && outAccept) begin
          mainNext = inEntry;
        end else if (inAccept) begin
          stateNext = FULL;
          skidNext  = inEntry;
        end else if (outAccept) begin
          stateNext = EMPTY;
          mainNext  = '0;
        end
      end
      FULL: begin
        if (outAccept) begin
          stateNext = ONE;
          mainNext  = skidQ;
          skidNext  = '0;
        end
      end
      default: begin
        stateNext = EMPTY;
        mainNext  = '0;
        skidNext  = '0;
      end
    endcase
    if (flush) begin
      stateNext = EMPTY;
      mainNext  = '0;
      skidNext  = '0;
    end
  end

  // State, payload and registered in_ready (precomputed from the next state).
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= EMPTY;
      mainQ    <= '0;
      skidQ    <= '0;
      inReadyQ <= 1'b1;
    end else begin
      state    <= stateNext;
      mainQ    <= mainNext;
      skidQ    <= skidNext;
      inReadyQ <= (stateNext != FULL);
    end
  end

  // Starved-cycle counter: downstream ready but nothing to give; saturates, survives flush.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bubbleQ <= '0;
    end else if (out_ready && !out_valid && (bubbleQ != {CNT_W{1'b1}})) begin
      bubbleQ <= bubbleQ + 1'b1;
    end
  end

endmodule

// File: doc/exec_stage_pipe.md
Name: exec_stage_pipe

Overview:
- Parametrised, elastic decode-to-execute pipeline register. It carries the control bundle (RegWrite/MemWrite/MemToReg/aluFunc, packed), two source operands and the destination register address.
- It adds a valid/ready handshake with a 2-entry skid buffer, so backpressure never forms a combinational ready path.
- It supports synchronous flush and zeroed bubbles, and has a saturating counter of starved cycles for performance debug.
- It sits between the decode/control stage and the ALU stage.

Parameters:
- DATA_W, 16, operand width (src1/src2).
- ADDR_W, 4, destination register address width.
- CTRL_W, 5, packed control width (RegWrite, MemWrite, MemToReg, aluFunc[1:0]).
- CNT_W, 16, bubble counter width.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- flush  input  1  synchronous flush; kills all held and incoming entries.
- in_valid  input  1  upstream entry present.
- in_ready  output  1  block can accept; driven directly from a register.
- ctrl_in  input  CTRL_W  control bundle.
- src1_in  input  DATA_W  operand 1.
- src2_in  input  DATA_W  operand 2.
- dest_in  input  ADDR_W  destination address.
- out_valid  output  1  output entry valid.
- out_ready  input  1  downstream accepts.
- ctrl_out  output  CTRL_W  registered control.
- src1_out  output  DATA_W  registered operand 1.
- src2_out  output  DATA_W  registered operand 2.
- dest_out  output  ADDR_W  registered destination.
- bubble_cnt  output  CNT_W  saturating count of cycles with out_ready=1 and out_valid=0.

Behaviour:
- Clock and reset: one clock. Reset is asynchronous and active-low. Both ports are named as the codebase names them (clk, reset).
- Reset values: state=EMPTY, out_valid=0, all payload outputs=0, main and skid payload registers=0, in_ready=1, bubble_cnt=0.
- Handshake: input accept = in_valid & in_ready; output accept = out_valid & out_ready.
- Storage: main register drives the outputs; skid register holds one overflow entry.
- in_ready = (state != FULL), taken from the state register only. There is no combinational path from out_ready to in_ready.
- State EMPTY:
  - accept → ONE, main ← input.
  - otherwise hold.
- State ONE:
  - accept and output accept → ONE, main ← input.
  - accept and no output accept → FULL, skid ← input.
  - no accept and output accept → EMPTY.
  - otherwise hold.
- State FULL:
  - in_ready=0.
  - output accept → ONE, main ← skid.
  - otherwise hold, all registers stable.
- out_valid = (state != EMPTY).
- Bubble zeroing: when out_valid=0, ctrl_out, src1_out, src2_out and dest_out read 0. The main register is cleared on any transition to EMPTY, so a bubble never carries RegWrite/MemWrite=1.
- Latency and throughput: 1 cycle from input accept to out_valid when not stalled; sustained 1 entry/cycle with out_ready held high.
- Ordering: strict FIFO order; no entry is dropped or duplicated except by flush.
- Flush: flush=1 at an edge → state=EMPTY, main and skid cleared to 0.
  - Any entry accepted in that same cycle is discarded.
  - in_ready=1 on the following cycle.
  - Flush dominates all other transitions.
  - bubble_cnt is not cleared by flush.
- bubble_cnt: increments when out_ready=1 and out_valid=0; saturates at all-ones. It is cleared only by reset.
- Reset mid-operation: async clear of everything regardless of state, including a FULL skid. No output glitches to nonzero during reset.
- Payload is never modified, only moved; no arithmetic on the datapath.

Test Plan:
- Streaming: out_ready=1; send src1=0x1111, 0x2222, 0x3333 back-to-back → each appears on src1_out exactly 1 cycle after accept, out_valid high for 3 consecutive cycles, in_ready stays 1.
- Backpressure: send A=0xAAAA, B=0xBBBB with out_ready=0 → state FULL, in_ready=0 from the cycle after B's accept, src1_out holds 0xAAAA. Raise out_ready → A then B delivered in order, in_ready=1 again.
- Flush while FULL, with a concurrent in_valid carrying C=0xCCCC → next cycle out_valid=0, all payload outputs 0, in_ready=1, C never appears at the output.
- Bubble: idle 5 cycles with out_ready=1 → bubble_cnt=5, ctrl_out=0. With CNT_W=2 over 5 cycles → bubble_cnt saturates at 3.
- Async reset asserted mid-cycle while FULL → all outputs 0 and in_ready=1 immediately, without waiting for a clock edge. After release the block resumes streaming correctly.
- Randomized valid/ready with a scoreboard over 10k cycles → output sequence equals the accepted input sequence, and no RegWrite=1 appears on a bubble.
